// File: rtl/ntt_butt_dual_pkg.sv
// Shared types and helpers for the dual-mode (CT/GS) NTT butterfly.
package ntt_butt_dual_pkg;

  // Per-beat butterfly flavour: Cooley-Tukey for forward NTT, Gentleman-Sande for inverse.
  typedef enum logic {
    BUTT_CT = 1'b0,
    BUTT_GS = 1'b1
  } butt_mode_e;

  // Width of the twiddle W and its Shoup companion WQ = floor(W*2^64/p).
  localparam int TWIDDLE_W = 64;

  // End-to-end latency in en=1 cycles: pre stage, Shoup multiply, combine, optional reduce.
  function automatic int butt_lat(input int mult_cycles, input int final_reduce);
    return 2 * mult_cycles + 3 + final_reduce;
  endfunction

endpackage

// File: rtl/ntt_butt_dual_if.sv
// Beat bus of the butterfly: operands, modulus, twiddle pair, results and status.
//
// Transfer rule: a beat is accepted on a rising clock edge where en=1 and in_valid=1.
// There is no ready; the only back-pressure is the global en, which freezes every
// stage (in_valid is ignored while en=0). A result is presented while out_valid=1 and
// is consumed on the next rising edge with en=1; with en=0 it is held unchanged.
interface ntt_butt_dual_if
  import ntt_butt_dual_pkg::*;
#(
  parameter int FSIZE = 60
) ();

  logic                 en;
  logic                 in_valid;
  butt_mode_e           mode;
  logic                 skip_level;
  logic [FSIZE-1:0]     a;
  logic [FSIZE-1:0]     b;
  logic [FSIZE-1:0]     p;
  logic [TWIDDLE_W-1:0] W;
  logic [TWIDDLE_W-1:0] WQ;
  logic [FSIZE-1:0]     a_out;
  logic [FSIZE-1:0]     b_out;
  logic                 out_valid;
  logic                 busy;

  modport master (
    output en, in_valid, mode, skip_level, a, b, p, W, WQ,
    input  a_out, b_out, out_valid, busy
  );

  modport slave (
    input  en, in_valid, mode, skip_level, a, b, p, W, WQ,
    output a_out, b_out, out_valid, busy
  );

endinterface

// File: rtl/ntt_butt_dual_shoup.sv
// Shoup modular multiply r = W*x - floor(x*WQ/2^64)*p (mod 2^FSIZE), r in [0,2p) for x < 4p.
// Two pipelined multipliers of MULT_CYCLES each plus one subtract stage: 2*MULT_CYCLES+1.
module butt_shoup_mul
  import ntt_butt_dual_pkg::*;
#(
  parameter int FSIZE       = 60,
  parameter int MULT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en_i,
  input  logic [FSIZE-1:0]     x_i,
  input  logic [TWIDDLE_W-1:0] w_i,
  input  logic [TWIDDLE_W-1:0] wq_i,
  input  logic [FSIZE-1:0]     p_i,
  output logic [FSIZE-1:0]     r_o
);

  localparam int M = MULT_CYCLES;

  typedef logic [FSIZE-1:0]           f_t;
  typedef logic [FSIZE+TWIDDLE_W-1:0] wide_t;

  // First multiplier: quotient estimate q, with W*x and p riding alongside.
  f_t q_q   [M];
  f_t wxa_q [M];
  f_t pa_q  [M];
  // Second multiplier: q*p, with W*x still riding alongside.
  f_t qp_q  [M];
  f_t wxb_q [M];
  f_t r_q;

  // Both multiplier pipes and the final subtract advance only when enabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < M; i++) begin
        q_q[i]   <= '0;
        wxa_q[i] <= '0;
        pa_q[i]  <= '0;
        qp_q[i]  <= '0;
        wxb_q[i] <= '0;
      end
      r_q <= '0;
    end else if (en_i) begin
      q_q[0]   <= f_t'((wide_t'(x_i) * wide_t'(wq_i)) >> TWIDDLE_W);
      wxa_q[0] <= f_t'(wide_t'(x_i) * wide_t'(w_i));
      pa_q[0]  <= p_i;
      for (int i = 1; i < M; i++) begin
        q_q[i]   <= q_q[i-1];
        wxa_q[i] <= wxa_q[i-1];
        pa_q[i]  <= pa_q[i-1];
      end
      qp_q[0]  <= q_q[M-1] * pa_q[M-1];
      wxb_q[0] <= wxa_q[M-1];
      for (int i = 1; i < M; i++) begin
        qp_q[i]  <= qp_q[i-1];
        wxb_q[i] <= wxb_q[i-1];
      end
      // Wraparound subtraction: the true value is in [0,2p), so mod 2^FSIZE is exact.
      r_q <= wxb_q[M-1] - qp_q[M-1];
    end
  end

  assign r_o = r_q;

endmodule

// File: rtl/ntt_butt_dual.sv
// Radix-2 NTT/INTT butterfly with per-beat CT/GS select, skip pass-through and
// optional final reduction. All beats share one latency, so order is preserved.
module ntt_butt_dual
  import ntt_butt_dual_pkg::*;
#(
  parameter int FSIZE        = 60,
  parameter int MULT_CYCLES  = 4,
  parameter int FINAL_REDUCE = 0
) (
  input logic             clk,
  input logic             rstn,
  ntt_butt_dual_if.slave  bus
);

  localparam int LAT = butt_lat(MULT_CYCLES, FINAL_REDUCE);
  // Side-band depth: pre-stage register plus the Shoup multiplier latency.
  localparam int SB  = 2 * MULT_CYCLES + 2;
  localparam int CW  = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);

  typedef logic [FSIZE-1:0] f_t;

  // Conditional subtract 2p then conditional subtract p: [0,4p) -> [0,p).
  function automatic f_t reduce_p(input f_t x, input f_t pm);
    f_t y;
    f_t two_pm;
    two_pm = pm << 1;
    y = (x >= two_pm) ? x - two_pm : x;
    return (y >= pm) ? y - pm : y;
  endfunction

  // Pre-stage combinational results.
  f_t two_p_in, s_sum, side_a_d, side_b_d, x_d;
  // Pre-stage registers feeding the multiplier.
  f_t                   x_q;
  logic [TWIDDLE_W-1:0] w_q, wq_q;
  // Side-band shift register; index 0 is the pre-stage register.
  f_t         sa_q   [SB];
  f_t         sb_q   [SB];
  f_t         p_q    [SB];
  butt_mode_e mode_q [SB];
  logic       skip_q [SB];
  logic       vld_q  [SB];
  // Multiplier result and combine stage.
  f_t   t;
  f_t   two_p_c, ca_d, cb_d;
  f_t   ca_q, cb_q;
  logic cv_q;
  // Final outputs, from either the combine or the reduce stage.
  f_t   out_a, out_b;
  logic out_v;
  // In-flight beat counter.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc, ret;

  // Pre-stage: multiplier operand per mode, and the a-side result that bypasses the multiplier.
  always_comb begin
    two_p_in = bus.p << 1;
    s_sum    = bus.a + bus.b;
    side_a_d = bus.a;
    side_b_d = bus.b;
    x_d      = bus.b;
    if (bus.mode == BUTT_GS) x_d = bus.a - bus.b + two_p_in;
    if (!bus.skip_level) begin
      if (bus.mode == BUTT_CT) side_a_d = (bus.a >= two_p_in) ? bus.a - two_p_in : bus.a;
      else                     side_a_d = (s_sum >= two_p_in) ? s_sum - two_p_in : s_sum;
    end
  end

  // Pre-stage register and enable-gated side-band delay line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q  <= '0;
      w_q  <= '0;
      wq_q <= '0;
      for (int i = 0; i < SB; i++) begin
        sa_q[i]   <= '0;
        sb_q[i]   <= '0;
        p_q[i]    <= '0;
        mode_q[i] <= BUTT_CT;
        skip_q[i] <= 1'b0;
        vld_q[i]  <= 1'b0;
      end
    end else if (bus.en) begin
      x_q       <= x_d;
      w_q       <= bus.W;
      wq_q      <= bus.WQ;
      sa_q[0]   <= side_a_d;
      sb_q[0]   <= side_b_d;
      p_q[0]    <= bus.p;
      mode_q[0] <= bus.mode;
      skip_q[0] <= bus.skip_level;
      vld_q[0]  <= bus.in_valid;
      for (int i = 1; i < SB; i++) begin
        sa_q[i]   <= sa_q[i-1];
        sb_q[i]   <= sb_q[i-1];
        p_q[i]    <= p_q[i-1];
        mode_q[i] <= mode_q[i-1];
        skip_q[i] <= skip_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  butt_shoup_mul #(
    .FSIZE       (FSIZE),
    .MULT_CYCLES (MULT_CYCLES)
  ) u_shoup (
    .clk  (clk),
    .rstn (rstn),
    .en_i (bus.en),
    .x_i  (x_q),
    .w_i  (w_q),
    .wq_i (wq_q),
    .p_i  (p_q[0]),
    .r_o  (t)
  );

  // Combine: CT adds/subtracts the product, GS forwards the pre-computed sum and the product.
  always_comb begin
    two_p_c = p_q[SB-1] << 1;
    ca_d    = sa_q[SB-1];
    cb_d    = sb_q[SB-1];
    if (!skip_q[SB-1]) begin
      if (mode_q[SB-1] == BUTT_CT) begin
        ca_d = sa_q[SB-1] + t;
        cb_d = sa_q[SB-1] - t + two_p_c;
      end else begin
        cb_d = t;
      end
    end
  end

  // Combine stage register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ca_q <= '0;
      cb_q <= '0;
      cv_q <= 1'b0;
    end else if (bus.en) begin
      ca_q <= ca_d;
      cb_q <= cb_d;
      cv_q <= vld_q[SB-1];
    end
  end

  if (FINAL_REDUCE != 0) begin : g_fr
    f_t   cp_q, fa_q, fb_q;
    logic cskip_q, fv_q;

    // Reduce stage; skip beats pass through untouched.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cp_q    <= '0;
        cskip_q <= 1'b0;
        fa_q    <= '0;
        fb_q    <= '0;
        fv_q    <= 1'b0;
      end else if (bus.en) begin
        cp_q    <= p_q[SB-1];
        cskip_q <= skip_q[SB-1];
        fa_q    <= cskip_q ? ca_q : reduce_p(ca_q, cp_q);
        fb_q    <= cskip_q ? cb_q : reduce_p(cb_q, cp_q);
        fv_q    <= cv_q;
      end
    end

    assign out_a = fa_q;
    assign out_b = fb_q;
    assign out_v = fv_q;
  end else begin : g_nofr
    assign out_a = ca_q;
    assign out_b = cb_q;
    assign out_v = cv_q;
  end

  assign acc = bus.en & bus.in_valid;
  assign ret = bus.en & out_v;

  // Next in-flight count: accept and retire together cancel; clamp at both ends.
  always_comb begin
    cnt_d = cnt_q;
    case ({acc, ret})
      2'b10:   cnt_d = (cnt_q == LAT_C) ? cnt_q : cnt_q + 1'b1;
      2'b01:   cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // In-flight counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.a_out     = out_a;
  assign bus.b_out     = out_b;
  assign bus.out_valid = out_v;
  assign bus.busy      = (cnt_q != '0);

endmodule

// File: tb/tb_ntt_butt_dual.sv
// Directed and randomised checks of ntt_butt_dual (FINAL_REDUCE=1 and 0 instances).
module tb_ntt_butt_dual;
  import ntt_butt_dual_pkg::*;

  localparam int FS   = 60;
  localparam int MC   = 4;
  localparam int LAT1 = butt_lat(MC, 1);
  localparam int EW   = 2 + 2 * FS;
  localparam int NRND = 10000;

  // Clock/reset and shared stimulus.
  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           en = 1'b0;
  logic           in_valid = 1'b0;
  butt_mode_e     mode = BUTT_CT;
  logic           skip = 1'b0;
  logic [FS-1:0]  a = '0, b = '0, p = '0;
  logic [63:0]    w = '0, wq = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int seen;
  logic prev_en;
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q0[$];

  always #5 clk = ~clk;

  ntt_butt_dual_if #(.FSIZE(FS)) bus1 ();
  ntt_butt_dual_if #(.FSIZE(FS)) bus0 ();

  assign bus1.en = en;       assign bus0.en = en;
  assign bus1.in_valid = in_valid; assign bus0.in_valid = in_valid;
  assign bus1.mode = mode;   assign bus0.mode = mode;
  assign bus1.skip_level = skip; assign bus0.skip_level = skip;
  assign bus1.a = a;         assign bus0.a = a;
  assign bus1.b = b;         assign bus0.b = b;
  assign bus1.p = p;         assign bus0.p = p;
  assign bus1.W = w;         assign bus0.W = w;
  assign bus1.WQ = wq;       assign bus0.WQ = wq;

  ntt_butt_dual #(.FSIZE(FS), .MULT_CYCLES(MC), .FINAL_REDUCE(1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1)
  );
  ntt_butt_dual #(.FSIZE(FS), .MULT_CYCLES(MC), .FINAL_REDUCE(0)) dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    skip     = 1'b0;
    a        = '0;
    b        = '0;
  endtask

  task automatic send(input butt_mode_e m, input logic s, input logic [FS-1:0] aa, input logic [FS-1:0] bb);
    in_valid = 1'b1;
    mode     = m;
    skip     = s;
    a        = aa;
    b        = bb;
    step();
  endtask

  task automatic expect_beat(input string tag, input logic [FS-1:0] ea, input logic [FS-1:0] eb);
    check({tag, "_v"}, bus1.out_valid, 1);
    check({tag, "_a"}, bus1.a_out, ea);
    check({tag, "_b"}, bus1.b_out, eb);
    step();
  endtask

  function automatic logic [FS-1:0] modp(input logic [127:0] v, input logic [FS-1:0] pm);
    logic [127:0] r;
    r = v % 128'(pm);
    return r[FS-1:0];
  endfunction

  function automatic logic [63:0] calc_wq(input logic [63:0] ww, input logic [FS-1:0] pm);
    logic [127:0] quo;
    quo = {ww, 64'h0} / 128'(pm);
    return quo[63:0];
  endfunction

  function automatic logic [FS-1:0] rnd_below(input logic [FS-1:0] bound);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return modp(r, bound);
  endfunction

  // Golden butterfly in plain modular arithmetic: {skip, mode, X mod p, Y mod p}.
  function automatic logic [EW-1:0] golden(input logic s, input butt_mode_e m,
                                           input logic [FS-1:0] aa, input logic [FS-1:0] bb,
                                           input logic [FS-1:0] pm, input logic [63:0] ww);
    logic [FS-1:0] x, y, tw;
    if (s) begin
      x = aa;
      y = bb;
    end else if (m == BUTT_CT) begin
      tw = modp(128'(bb) * 128'(ww), pm);
      x  = modp(128'(aa) + 128'(tw), pm);
      y  = modp(128'(aa) + 128'(pm) - 128'(tw), pm);
    end else begin
      x = modp(128'(aa) + 128'(bb), pm);
      y = modp((128'(aa) + 2 * 128'(pm) - 128'(bb)) * 128'(ww), pm);
    end
    return {s, m, x, y};
  endfunction

  // Scoreboard: pop and compare one beat per DUT each time a fresh result appears.
  task automatic scan(input logic adv);
    logic [EW-1:0] e;
    logic [FS-1:0] ex, ey, bound;
    if (adv && bus1.out_valid) begin
      check("rnd1_have", exp_q1.size() != 0, 1);
      if (exp_q1.size() != 0) begin
        e  = exp_q1.pop_front();
        ex = e[2*FS-1:FS];
        ey = e[FS-1:0];
        check("rnd1_a", bus1.a_out, ex);
        check("rnd1_b", bus1.b_out, ey);
      end
    end
    if (adv && bus0.out_valid) begin
      check("rnd0_have", exp_q0.size() != 0, 1);
      if (exp_q0.size() != 0) begin
        e  = exp_q0.pop_front();
        ex = e[2*FS-1:FS];
        ey = e[FS-1:0];
        if (e[EW-1]) begin
          check("rnd0_skip_a", bus0.a_out, ex);
          check("rnd0_skip_b", bus0.b_out, ey);
        end else begin
          bound = e[EW-2] ? (p << 1) : (p << 2);
          check("rnd0_a", modp(128'(bus0.a_out), p), ex);
          check("rnd0_b", modp(128'(bus0.b_out), p), ey);
          check("rnd0_a_rng", bus0.a_out < bound, 1);
          check("rnd0_b_rng", bus0.b_out < bound, 1);
        end
      end
    end
  endtask

  initial begin
    // Reset state.
    en = 1'b1;
    p  = 17;
    w  = 3;
    wq = calc_wq(64'd3, 60'd17);
    idle();
    repeat (2) step();
    check("rst_valid", bus1.out_valid, 0);
    check("rst_a", bus1.a_out, 0);
    check("rst_b", bus1.b_out, 0);
    check("rst_busy", bus1.busy, 0);
    rstn = 1'b1;
    step();

    // Single CT beat: exact latency and a one-cycle valid pulse.
    send(BUTT_CT, 1'b0, 5, 7);
    idle();
    check("ct_busy", bus1.busy, 1);
    repeat (LAT1 - 2) step();
    check("ct_early", bus1.out_valid, 0);
    step();
    expect_beat("ct", 9, 1);
    check("ct_pulse", bus1.out_valid, 0);
    check("ct_idle", bus1.busy, 0);

    // Back-to-back CT/GS interleave.
    send(BUTT_CT, 1'b0, 5, 7);
    send(BUTT_GS, 1'b0, 5, 7);
    send(BUTT_CT, 1'b0, 1, 2);
    send(BUTT_GS, 1'b0, 16, 3);
    idle();
    repeat (LAT1 - 5) step();
    check("ilv_early", bus1.out_valid, 0);
    step();
    expect_beat("ilv0", 9, 1);
    expect_beat("ilv1", 12, 11);
    expect_beat("ilv2", 7, 12);
    expect_beat("ilv3", 2, 5);
    check("ilv_end", bus1.out_valid, 0);

    // Skip beat between two CT beats (first CT has a >= 2p, b near 4p).
    send(BUTT_CT, 1'b0, 60, 67);
    send(BUTT_GS, 1'b1, 40, 50);
    send(BUTT_CT, 1'b0, 5, 7);
    idle();
    repeat (LAT1 - 3) step();
    expect_beat("skp0", 6, 12);
    expect_beat("skp1", 40, 50);
    expect_beat("skp2", 9, 1);
    check("skp_end", bus1.out_valid, 0);

    // Stall while the first result is on the output; in_valid is ignored meanwhile.
    send(BUTT_CT, 1'b0, 5, 7);
    send(BUTT_GS, 1'b0, 5, 7);
    send(BUTT_CT, 1'b0, 1, 2);
    idle();
    repeat (LAT1 - 3) step();
    check("stl_v0", bus1.out_valid, 1);
    check("stl_a0", bus1.a_out, 9);
    en       = 1'b0;
    in_valid = 1'b1;
    a        = 33;
    b        = 33;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stl_hold_v", bus1.out_valid, 1);
      check("stl_hold_a", bus1.a_out, 9);
      check("stl_hold_b", bus1.b_out, 1);
      check("stl_busy", bus1.busy, 1);
    end
    en = 1'b1;
    idle();
    step();
    expect_beat("stl1", 12, 11);
    expect_beat("stl2", 7, 12);
    check("stl_end_v", bus1.out_valid, 0);
    check("stl_end_busy", bus1.busy, 0);

    // Asynchronous reset with four beats in flight.
    for (int i = 0; i < 4; i++) send(BUTT_CT, 1'b0, 5, 7);
    idle();
    repeat (2) step();
    check("ar_busy_pre", bus1.busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("ar_valid", bus1.out_valid, 0);
    check("ar_busy", bus1.busy, 0);
    check("ar_a", bus1.a_out, 0);
    step();
    rstn = 1'b1;
    seen = 0;
    repeat (LAT1 + 2) begin
      step();
      if (bus1.out_valid) seen++;
    end
    check("ar_stale", seen, 0);

    // Random beats on a large modulus, both reduce variants, random stalls.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    p = 60'h3FF_FFFF_FFFF_FFC5;
    for (int i = 0; i < NRND; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      mode     = butt_mode_e'($urandom_range(0, 1));
      skip     = ($urandom_range(0, 15) == 0);
      w        = 64'(rnd_below(p));
      wq       = calc_wq(w, p);
      if (mode == BUTT_CT) begin
        a = rnd_below(p << 2);
        b = rnd_below(p << 2);
      end else begin
        a = rnd_below(p << 1);
        b = rnd_below(p << 1);
      end
      if (en && in_valid) begin
        exp_q1.push_back(golden(skip, mode, a, b, p, w));
        exp_q0.push_back(golden(skip, mode, a, b, p, w));
      end
      prev_en = en;
      step();
      scan(prev_en);
    end
    en = 1'b1;
    idle();
    repeat (LAT1 + 2) begin
      step();
      scan(1'b1);
    end
    check("rnd1_drained", exp_q1.size(), 0);
    check("rnd0_drained", exp_q0.size(), 0);
    check("rnd1_busy", bus1.busy, 0);
    check("rnd0_busy", bus0.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
